// File: rtl/des_keysched_dec.sv
// Iterative DES decryption key schedule: loads PC-1 of the key, then emits
// K16..K1 over a valid/ready handshake by right-rotating the C/D halves.
module des_keysched_dec (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] key_i,
   input  logic        start_i,
   output logic        busy_o,
   output logic        subkey_valid_o,
   input  logic        subkey_ready_i,
   output logic [47:0] subkey_o,
   output logic [3:0]  round_o,
   output logic        done_o
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Table entries use standard DES numbering: bit 1 is the MSB.
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;

   logic [55:0] pc1_key;
   logic [55:0] cd_q;
   logic        shift_one;

   function automatic logic [27:0] ror28(input logic [27:0] x, input logic by_one);
      ror28 = by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   generate
      for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
         localparam int SRC = 64 - PC1_TAB[gi];
         assign pc1_key[55-gi] = key_i[SRC];
      end
   endgenerate

   assign cd_q = {c_q, d_q};

   generate
      for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
         localparam int SRC = 56 - PC2_TAB[gi];
         assign subkey_o[47-gi] = cd_q[SRC];
      end
   endgenerate

   // Encryption shift of round cnt+1: single shifts fall on rounds 16, 9 and 2.
   assign shift_one = (cnt_q == 4'd15) || (cnt_q == 4'd8) || (cnt_q == 4'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               // No pre-rotation: C16/D16 equal C0/D0 after the full 28-bit shift.
               c_d     = pc1_key[55:28];
               d_d     = pc1_key[27:0];
               cnt_d   = 4'd15;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (subkey_ready_i) begin
               if (cnt_q == 4'd0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  c_d   = ror28(c_q, shift_one);
                  d_d   = ror28(d_q, shift_one);
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      subkey_valid_o = (state_q == S_RUN);
      busy_o         = (state_q == S_RUN);
      round_o        = cnt_q;
      done_o         = done_q;
   end

endmodule
